instr_encoder: RTL

- Inverse of the core's main decoder: takes decoded instruction fields (format, opcode, register indices, functs, full-width immediate) over a valid/ready stream and packs them into 32-bit RV32I instruction words.
- Writes the words sequentially into the instruction-memory write port.
- Used by the program-load path and by self-checking benches to build instruction images.
- Checks immediate range and alignment per format.

---
 rtl/rv32i_pkg.sv | 35 +++
 rtl/instr_pack.sv | 56 +++++
 rtl/instr_encoder.sv | 113 +++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I instruction formats, opcodes, NOP and immediate range helper
package rv32i_pkg;

    // Format codes match the decoder's imm_src encoding, with R and illegal appended
    typedef enum logic [2:0] {
        FMT_I   = 3'b000,
        FMT_S   = 3'b001,
        FMT_B   = 3'b010,
        FMT_U   = 3'b011,
        FMT_J   = 3'b100,
        FMT_ISH = 3'b101,
        FMT_R   = 3'b110,
        FMT_ILL = 3'b111
    } fmt_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // True when v is representable as an n-bit two's-complement value
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned n);
        logic [31:0] s;
        s = 32'($signed(v) >>> (n - 1));
        return s == '0 || s == '1;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational RV32I field packer and immediate range/alignment checker
//   fmt, opcode, rd, rs1, rs2, funct3, funct7, imm : decoded fields
//   word : packed instruction (truncated immediate bits on range failure)
//   err  : immediate out of range / misaligned, or illegal format
module instr_pack
    import rv32i_pkg::*;
(
    input  fmt_t        fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        err
);

    always_comb begin
        word = NOP;
        err  = 1'b1;
        case (fmt)
            FMT_I: begin
                word = {imm[11:0], rs1, funct3, rd, opcode};
                err  = !fits_signed(imm, 12);
            end
            FMT_S: begin
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                err  = !fits_signed(imm, 12);
            end
            FMT_B: begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                err  = !fits_signed(imm, 13) || imm[0];
            end
            FMT_U: begin
                word = {imm[31:12], rd, opcode};
                err  = imm[11:0] != 12'd0;
            end
            FMT_J: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                err  = !fits_signed(imm, 21) || imm[0];
            end
            FMT_ISH: begin
                word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                err  = imm[31:5] != 27'd0;
            end
            FMT_R: begin
                word = {funct7, rs2, rs1, funct3, rd, opcode};
                err  = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streams decoded field bundles into packed RV32I words written to instruction memory
//   clk_ie, rst_ie (async, active-low) ; start_ie begins an image (IDLE only)
//   in_valid/in_ready/in_last + fields : input bundle stream
//   imem_we/imem_addr/imem_wdata       : sequential memory write port, 1-cycle latency
//   busy, done, err_imm, err_sticky, err_full, word_count : status
module instr_encoder
    import rv32i_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk_ie,
    input  logic              rst_ie,
    input  logic              start_ie,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_imm,
    output logic              err_sticky,
    output logic              err_full,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   CAP  = (ADDR_W + 1)'(MAX_WORDS);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       word;
    logic              word_err;
    logic              accept;
    logic              full_hit;

    instr_pack u_pack (
        .fmt    (fmt_t'(fmt)),
        .opcode (opcode),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .funct3 (funct3),
        .funct7 (funct7),
        .imm    (imm),
        .word   (word),
        .err    (word_err)
    );

    // word_count already includes the word sitting in the output register,
    // so it doubles as the "written + pending" occupancy
    assign in_ready = state == S_RUN && word_count < CAP;
    assign accept   = in_valid && in_ready;
    assign full_hit = accept && !in_last && word_count + 1'b1 == CAP;
    assign busy     = state == S_RUN || state == S_FLUSH;
    assign done     = state == S_DONE;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = start_ie ? S_RUN : S_IDLE;
            S_RUN:   state_nx = accept && (in_last || full_hit) ? S_FLUSH : S_RUN;
            S_FLUSH: state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_ie or negedge rst_ie) begin
        if (!rst_ie) begin
            state      <= S_IDLE;
            ptr        <= BASE;
            imem_we    <= 1'b0;
            imem_addr  <= BASE;
            imem_wdata <= '0;
            err_imm    <= 1'b0;
            err_sticky <= 1'b0;
            err_full   <= 1'b0;
            word_count <= '0;
        end else begin
            state   <= state_nx;
            imem_we <= accept;
            err_imm <= accept && word_err;
            if (state == S_IDLE && start_ie) begin
                ptr        <= BASE;
                word_count <= '0;
                err_sticky <= 1'b0;
                err_full   <= 1'b0;
            end
            if (accept) begin
                imem_addr  <= ptr;
                imem_wdata <= word;
                ptr        <= ptr + 1'b1;
                word_count <= word_count + 1'b1;
                err_sticky <= err_sticky || word_err;
                err_full   <= err_full || full_hit;
            end
        end
    end

endmodule
